// File: rtl/video_pkg.sv
// Shared definitions for the video scanout slice: active width, fetch FSM
// states and the RGB565 pixel layout.
package video_pkg;

  localparam int unsigned H_ACTIVE = 512;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_FILL
  } fetch_state_t;

  typedef struct packed {
    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;
  } rgb565_t;

  function automatic rgb565_t rgb565_blank(input logic [15:0] word, input logic en);
    return en ? rgb565_t'(word) : '0;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module line_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/video_line_fetch.sv
// Raster timing at half PixelClk2, one-line-ahead SDRAM row fetch into a
// ping-pong line RAM, and RGB565 scanout with aligned syncs.
module video_line_fetch
  import video_pkg::*;
#(
  parameter int unsigned H_TOTAL      = 672,
  parameter int unsigned H_SYNC_START = 536,
  parameter int unsigned H_SYNC_END   = 600,
  parameter int unsigned V_ACTIVE     = 384,
  parameter int unsigned V_TOTAL      = 410,
  parameter int unsigned V_SYNC_START = 390,
  parameter int unsigned V_SYNC_END   = 392
) (
  input  logic        PixelClk2,
  input  logic        Reset,
  input  logic [10:0] BaseRow,
  output logic        StartBuffer,
  output logic [10:0] GetRow,
  input  logic [8:0]  BufferAddr,
  input  logic [15:0] BufferData,
  input  logic        BufferWrite,
  output logic [4:0]  Red,
  output logic [5:0]  Green,
  output logic [4:0]  Blue,
  output logic        HSync,
  output logic        VSync,
  output logic        DataEnable,
  output logic        Underrun
);

  localparam logic [9:0] LP_H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] LP_H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] LP_HS_BEG  = 10'(H_SYNC_START);
  localparam logic [9:0] LP_HS_END  = 10'(H_SYNC_END);
  localparam logic [8:0] LP_V_LAST  = 9'(V_TOTAL - 1);
  localparam logic [8:0] LP_V_ACT   = 9'(V_ACTIVE);
  localparam logic [8:0] LP_VS_BEG  = 9'(V_SYNC_START);
  localparam logic [8:0] LP_VS_END  = 9'(V_SYNC_END);

  logic         r_pix_en;
  logic [9:0]   r_hcount;
  logic [8:0]   r_vcount;
  logic [8:0]   w_v_next;
  logic         w_issue;

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic         w_load;
  logic         w_ack;
  logic         w_bw_fall;
  logic         r_bw_d;
  logic         r_start;
  logic [10:0]  r_get_row;
  logic         r_fill_bank;
  logic         r_underrun;

  logic [15:0]  w_rdata;
  logic         w_de;
  logic         w_hs;
  logic         w_vs;
  logic         r_de_d1;
  logic         r_hs_d1;
  logic         r_vs_d1;
  logic         r_de;
  logic         r_hs;
  logic         r_vs;
  rgb565_t      r_rgb;

  // Raster counters
  assign w_v_next = (r_vcount == LP_V_LAST) ? '0 : r_vcount + 9'd1;
  assign w_issue  = r_pix_en && (r_hcount == '0) && (w_v_next < LP_V_ACT);

  always_ff @(posedge PixelClk2) begin
    if (Reset) begin
      r_pix_en <= 1'b0;
      r_hcount <= '0;
      r_vcount <= '0;
    end else begin
      r_pix_en <= ~r_pix_en;
      if (r_pix_en) begin
        if (r_hcount == LP_H_LAST) begin
          r_hcount <= '0;
          r_vcount <= w_v_next;
        end else begin
          r_hcount <= r_hcount + 10'd1;
        end
      end
    end
  end

  // Fetch FSM
  assign w_bw_fall = r_bw_d & ~BufferWrite;

  always_ff @(posedge PixelClk2) begin
    if (Reset) r_state <= FETCH_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_ack        = 1'b0;
    case (r_state)
      FETCH_IDLE: begin
        if (w_issue) begin
          w_state_next = FETCH_REQ;
          w_load       = 1'b1;
        end
      end
      FETCH_REQ: begin
        if (BufferWrite) begin
          w_state_next = FETCH_FILL;
          w_ack        = 1'b1;
        end
      end
      FETCH_FILL: begin
        if (w_bw_fall) w_state_next = FETCH_IDLE;
      end
      default: w_state_next = FETCH_IDLE;
    endcase
  end

  // An issue landing on the FILL->IDLE cycle still sees a busy FSM.
  always_ff @(posedge PixelClk2) begin
    if (Reset) begin
      r_bw_d      <= 1'b0;
      r_start     <= 1'b0;
      r_get_row   <= '0;
      r_fill_bank <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_bw_d <= BufferWrite;
      if (w_load) begin
        r_start     <= 1'b1;
        r_get_row   <= BaseRow + {2'b00, w_v_next};
        r_fill_bank <= w_v_next[0];
      end else if (w_ack) begin
        r_start <= 1'b0;
      end
      if (w_issue && (r_state != FETCH_IDLE)) r_underrun <= 1'b1;
    end
  end

  line_ram #(
    .ADDR_W(10),
    .DATA_W(16)
  ) u_line_ram (
    .i_clk  (PixelClk2),
    .i_we   (BufferWrite),
    .i_waddr({r_fill_bank, BufferAddr}),
    .i_wdata(BufferData),
    .i_raddr({r_vcount[0], r_hcount[8:0]}),
    .o_rdata(w_rdata)
  );

  // Video pipeline: syncs/enable delayed to match RAM read + output register
  assign w_de = (r_hcount < LP_H_ACT) && (r_vcount < LP_V_ACT);
  assign w_hs = !((r_hcount >= LP_HS_BEG) && (r_hcount < LP_HS_END));
  assign w_vs = !((r_vcount >= LP_VS_BEG) && (r_vcount < LP_VS_END));

  always_ff @(posedge PixelClk2) begin
    if (Reset) begin
      r_de_d1 <= 1'b0;
      r_hs_d1 <= 1'b1;
      r_vs_d1 <= 1'b1;
      r_de    <= 1'b0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_rgb   <= '0;
    end else begin
      r_de_d1 <= w_de;
      r_hs_d1 <= w_hs;
      r_vs_d1 <= w_vs;
      r_de    <= r_de_d1;
      r_hs    <= r_hs_d1;
      r_vs    <= r_vs_d1;
      r_rgb   <= rgb565_blank(w_rdata, r_de_d1);
    end
  end

  assign StartBuffer = r_start;
  assign GetRow      = r_get_row;
  assign Underrun    = r_underrun;
  assign Red         = r_rgb.red;
  assign Green       = r_rgb.green;
  assign Blue        = r_rgb.blue;
  assign HSync       = r_hs;
  assign VSync       = r_vs;
  assign DataEnable  = r_de;

endmodule

// File: tb/tb_video_line_fetch.sv
// Directed bench for video_line_fetch with a short frame (8 lines) and a
// behavioural SDRAM line-buffer controller.
module tb_video_line_fetch;

  localparam int unsigned HT  = 672;
  localparam int unsigned VA  = 4;
  localparam int unsigned VT  = 8;
  localparam int unsigned VS0 = 5;
  localparam int unsigned VS1 = 7;

  logic        clk = 1'b0;
  logic        Reset;
  logic [10:0] BaseRow;
  logic        StartBuffer;
  logic [10:0] GetRow;
  logic [8:0]  BufferAddr;
  logic [15:0] BufferData;
  logic        BufferWrite;
  logic [4:0]  Red;
  logic [5:0]  Green;
  logic [4:0]  Blue;
  logic        HSync;
  logic        VSync;
  logic        DataEnable;
  logic        Underrun;

  int unsigned t;
  int          n_checks = 0;
  int          n_bad    = 0;
  int          ack_delay = 20;

  always #5 clk = ~clk;

  video_line_fetch #(
    .H_TOTAL     (HT),
    .H_SYNC_START(536),
    .H_SYNC_END  (600),
    .V_ACTIVE    (VA),
    .V_TOTAL     (VT),
    .V_SYNC_START(VS0),
    .V_SYNC_END  (VS1)
  ) dut (
    .PixelClk2  (clk),
    .Reset      (Reset),
    .BaseRow    (BaseRow),
    .StartBuffer(StartBuffer),
    .GetRow     (GetRow),
    .BufferAddr (BufferAddr),
    .BufferData (BufferData),
    .BufferWrite(BufferWrite),
    .Red        (Red),
    .Green      (Green),
    .Blue       (Blue),
    .HSync      (HSync),
    .VSync      (VSync),
    .DataEnable (DataEnable),
    .Underrun   (Underrun)
  );

  // t = number of clocks since the last reset clock
  always @(posedge clk) begin
    if (Reset) t <= 0;
    else       t <= t + 1;
  end

  function automatic logic [15:0] pix_word(input logic [10:0] row, input logic [8:0] addr);
    if (addr == 9'd5 && row == 11'h102) return 16'hF800;
    return {row[6:0], addr};
  endfunction

  // Controller model: ack after ack_delay clocks, then 516 consecutive strobes
  initial begin
    logic [10:0] row;
    int          dly;
    bit          aborted;
    BufferWrite = 1'b0;
    BufferAddr  = '0;
    BufferData  = '0;
    forever begin
      @(negedge clk);
      if (!Reset && StartBuffer) begin
        row     = GetRow;
        dly     = ack_delay;
        aborted = 1'b0;
        for (int i = 0; i < dly && !aborted; i++) begin
          @(negedge clk);
          if (Reset) aborted = 1'b1;
        end
        for (int k = 0; k < 516 && !aborted; k++) begin
          BufferWrite = 1'b1;
          BufferAddr  = 9'(k);
          BufferData  = pix_word(row, 9'(k));
          @(negedge clk);
          if (Reset) aborted = 1'b1;
        end
        BufferWrite = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got t=%0d want finish before timeout", t);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    Reset   = 1'b1;
    BaseRow = 11'h100;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({StartBuffer, GetRow} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_fetch: got start=%0b row=%0h want 0 0", StartBuffer, GetRow);
    end
    n_checks++;
    if ({Red, Green, Blue, DataEnable} !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_video: got rgb=%0h de=%0b want 0 0", {Red, Green, Blue}, DataEnable);
    end
    n_checks++;
    if ({HSync, VSync} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_syncs: got hs=%0b vs=%0b want 1 1", HSync, VSync);
    end
    n_checks++;
    if (Underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_underrun: got %0b want 0", Underrun);
    end
    Reset = 1'b0;
  endtask

  task automatic test_fetch_schedule();
    int unsigned exp_t[4] = '{2, 1346, 2690, 9410};
    logic [10:0] exp_r[4] = '{11'h101, 11'h102, 11'h103, 11'h100};
    int unsigned rise_t[4] = '{default: 0};
    logic [10:0] rise_r[4] = '{default: '0};
    int          n_rise = 0;
    int unsigned fall_t = 0;
    logic        prev_sb = 1'b0;
    while (t < 9412) begin
      @(negedge clk);
      if (StartBuffer && !prev_sb) begin
        if (n_rise < 4) begin
          rise_t[n_rise] = t;
          rise_r[n_rise] = GetRow;
        end
        n_rise++;
      end
      if (!StartBuffer && prev_sb && fall_t == 0) fall_t = t;
      prev_sb = StartBuffer;
    end
    n_checks++;
    if (n_rise != 4) begin
      n_bad++;
      $display("FAIL sched_count: got %0d fetches want 4", n_rise);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rise_t[i] != exp_t[i] || rise_r[i] !== exp_r[i]) begin
        n_bad++;
        $display("FAIL sched_fetch%0d: got t=%0d row=%0h want t=%0d row=%0h",
                 i, rise_t[i], rise_r[i], exp_t[i], exp_r[i]);
      end
    end
    n_checks++;
    if (fall_t != 23) begin
      n_bad++;
      $display("FAIL sched_ack: got StartBuffer fall t=%0d want 23", fall_t);
    end
    n_checks++;
    if (Underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL sched_underrun: got %0b want 0", Underrun);
    end
  endtask

  // Second frame: line 3 fetched with BaseRow=0x7FF, so row wraps to 0x002
  task automatic test_frame();
    logic [10:0] line_row[4] = '{11'h100, 11'h101, 11'h102, 11'h002};
    int unsigned exp_t[4] = '{10754, 12098, 13442, 20162};
    logic [10:0] exp_r[4] = '{11'h101, 11'h102, 11'h002, 11'h7FF};
    int unsigned rise_t[4] = '{default: 0};
    logic [10:0] rise_r[4] = '{default: '0};
    int          n_rise = 0;
    logic        prev_sb;
    int unsigned p, h, v;
    logic        e_de, e_hs, e_vs;
    logic [15:0] e_px, g_px;
    int de_bad = 0, hs_bad = 0, vs_bad = 0, px_bad = 0, l0_bad = 0;
    int de_cnt = 0, hs_low = 0, vs_low = 0, hits = 0, hits_at = 0;
    while (t < 10753) @(negedge clk);
    prev_sb = StartBuffer;
    for (int i = 0; i < 10752; i++) begin
      @(negedge clk);
      if (t == 12752) BaseRow = 11'h7FF;
      p    = (t - 2) / 2;
      h    = p % HT;
      v    = (p / HT) % VT;
      e_de = (h < 512) && (v < VA);
      e_hs = !(h >= 536 && h < 600);
      e_vs = !(v >= VS0 && v < VS1);
      e_px = e_de ? pix_word(line_row[v % 4], 9'(h)) : 16'h0000;
      g_px = {Red, Green, Blue};
      if (DataEnable !== e_de) de_bad++;
      if (HSync !== e_hs) hs_bad++;
      if (VSync !== e_vs) vs_bad++;
      if (g_px !== e_px) begin
        px_bad++;
        if (v == 0) l0_bad++;
      end
      if (DataEnable === 1'b1) de_cnt++;
      if (HSync === 1'b0) hs_low++;
      if (VSync === 1'b0) vs_low++;
      if (Red == 5'd31 && Green == 6'd0 && Blue == 5'd0 && DataEnable === 1'b1) begin
        hits++;
        if (v == 2 && h == 5) hits_at++;
      end
      if (StartBuffer && !prev_sb) begin
        if (n_rise < 4) begin
          rise_t[n_rise] = t;
          rise_r[n_rise] = GetRow;
        end
        n_rise++;
      end
      prev_sb = StartBuffer;
    end
    n_checks++;
    if (de_bad != 0 || de_cnt != 4096) begin
      n_bad++;
      $display("FAIL frame_de: got %0d errors, %0d high want 0, 4096", de_bad, de_cnt);
    end
    n_checks++;
    if (hs_bad != 0 || hs_low != 1024) begin
      n_bad++;
      $display("FAIL frame_hsync: got %0d errors, %0d low want 0, 1024", hs_bad, hs_low);
    end
    n_checks++;
    if (vs_bad != 0 || vs_low != 2688) begin
      n_bad++;
      $display("FAIL frame_vsync: got %0d errors, %0d low want 0, 2688", vs_bad, vs_low);
    end
    n_checks++;
    if (l0_bad != 0) begin
      n_bad++;
      $display("FAIL frame_line0: got %0d pixel errors want 0", l0_bad);
    end
    n_checks++;
    if (px_bad != 0) begin
      n_bad++;
      $display("FAIL frame_pixels: got %0d pixel errors want 0", px_bad);
    end
    n_checks++;
    if (hits != 2 || hits_at != 2) begin
      n_bad++;
      $display("FAIL frame_red_pixel: got %0d hits (%0d at h5 v2) want 2 (2)", hits, hits_at);
    end
    n_checks++;
    if (n_rise != 4) begin
      n_bad++;
      $display("FAIL frame_fetch_count: got %0d want 4", n_rise);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rise_t[i] != exp_t[i] || rise_r[i] !== exp_r[i]) begin
        n_bad++;
        $display("FAIL frame_fetch%0d: got t=%0d row=%0h want t=%0d row=%0h",
                 i, rise_t[i], rise_r[i], exp_t[i], exp_r[i]);
      end
    end
    n_checks++;
    if (Underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_underrun: got %0b want 0", Underrun);
    end
  endtask

  task automatic test_underrun();
    ack_delay = 4000;
    while (t < 22849) @(negedge clk);
    n_checks++;
    if (Underrun !== 1'b0 || StartBuffer !== 1'b1) begin
      n_bad++;
      $display("FAIL underrun_before: got underrun=%0b start=%0b want 0 1", Underrun, StartBuffer);
    end
    @(negedge clk);
    n_checks++;
    if (Underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL underrun_set: got %0b want 1 at t=%0d", Underrun, t);
    end
    n_checks++;
    if (GetRow !== 11'h000) begin
      n_bad++;
      $display("FAIL underrun_row: got %0h want 0", GetRow);
    end
    while (t < 24300) @(negedge clk);
    n_checks++;
    if (Underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL underrun_sticky: got %0b want 1", Underrun);
    end
  endtask

  task automatic test_reset_in_fill();
    int unsigned rise_t[2] = '{default: 0};
    logic [10:0] rise_r[2] = '{default: '0};
    int          n_rise = 0;
    int unsigned fall_t = 0;
    logic        prev_sb = 1'b0;
    Reset     = 1'b1;
    ack_delay = 20;
    BaseRow   = 11'h100;
    @(negedge clk);
    n_checks++;
    if (Underrun !== 1'b0 || StartBuffer !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_clears_underrun: got underrun=%0b start=%0b want 0 0", Underrun, StartBuffer);
    end
    @(negedge clk);
    Reset = 1'b0;
    while (t < 300) begin
      @(negedge clk);
      if (StartBuffer && !prev_sb && rise_t[0] == 0) rise_t[0] = t;
      if (!StartBuffer && prev_sb && fall_t == 0) fall_t = t;
      prev_sb = StartBuffer;
    end
    n_checks++;
    if (rise_t[0] != 2 || fall_t != 23 || BufferWrite !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_reached: got rise=%0d fall=%0d bw=%0b want 2 23 1", rise_t[0], fall_t, BufferWrite);
    end
    Reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({StartBuffer, GetRow, Underrun} !== 13'h0) begin
      n_bad++;
      $display("FAIL fill_rst_fetch: got start=%0b row=%0h underrun=%0b want 0 0 0", StartBuffer, GetRow, Underrun);
    end
    n_checks++;
    if ({Red, Green, Blue, DataEnable, HSync, VSync} !== 19'b0000000000000000011) begin
      n_bad++;
      $display("FAIL fill_rst_video: got rgb=%0h de=%0b hs=%0b vs=%0b want 0 0 1 1",
               {Red, Green, Blue}, DataEnable, HSync, VSync);
    end
    @(negedge clk);
    Reset   = 1'b0;
    rise_t  = '{default: 0};
    fall_t  = 0;
    prev_sb = 1'b0;
    while (t < 1400) begin
      @(negedge clk);
      if (StartBuffer && !prev_sb) begin
        if (n_rise < 2) begin
          rise_t[n_rise] = t;
          rise_r[n_rise] = GetRow;
        end
        n_rise++;
      end
      if (!StartBuffer && prev_sb && fall_t == 0) fall_t = t;
      prev_sb = StartBuffer;
    end
    n_checks++;
    if (n_rise != 2 || rise_t[0] != 2 || rise_r[0] !== 11'h101) begin
      n_bad++;
      $display("FAIL resume_first: got n=%0d t=%0d row=%0h want 2 2 101", n_rise, rise_t[0], rise_r[0]);
    end
    n_checks++;
    if (rise_t[1] != 1346 || rise_r[1] !== 11'h102 || fall_t != 23) begin
      n_bad++;
      $display("FAIL resume_second: got t=%0d row=%0h fall=%0d want 1346 102 23", rise_t[1], rise_r[1], fall_t);
    end
    n_checks++;
    if (Underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL resume_underrun: got %0b want 0", Underrun);
    end
  endtask

  initial begin
    Reset   = 1'b1;
    BaseRow = 11'h100;
    test_reset();
    test_fetch_schedule();
    test_frame();
    test_underrun();
    test_reset_in_fill();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
